// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A-style PIC command front end:
//   - pic_state_t : initialization-sequence FSM states
//   - OCW2 command codes (R, SL, EOI = D7:5)
//   - bit positions inside the ICW/OCW data bytes
// -----------------------------------------------------------------------------
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } pic_state_t;

   // OCW2 command codes, D7:5 = {R, SL, EOI}
   localparam logic [2:0] NS_EOI     = 3'b001;
   localparam logic [2:0] S_EOI      = 3'b011;
   localparam logic [2:0] ROT_NS_EOI = 3'b101;
   localparam logic [2:0] ROT_S_EOI  = 3'b111;
   localparam logic [2:0] SET_AR     = 3'b100;
   localparam logic [2:0] CLR_AR     = 3'b000;

   // ICW1 fields (A0 = 0)
   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int ICW1_SEL  = 4;   // D4 = 1 marks ICW1 on an A0 = 0 write

   // ICW4 fields (A0 = 1)
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_SFNM = 4;

   // OCW2/OCW3 discrimination once D4 = 0: D3 = 0 -> OCW2, D3 = 1 -> OCW3
   localparam int OCW_SEL   = 3;

   // OCW3 fields
   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;

   // ICW2 carries the vector base in its upper five bits
   function automatic logic [4:0] icw2_base(input logic [7:0] d);
      return d[7:3];
   endfunction

endpackage

// File: rtl/pic_control_logic_if.sv
// -----------------------------------------------------------------------------
// pic_control_logic_if
// CPU-side bus of the PIC command front end.
//   csN    : chip select, active low
//   wrN    : write strobe, active low
//   rdN    : read strobe, active low
//   A0     : register address bit
//   dataIn : write data
// master = CPU side (drives the bus), slave = PIC side (samples the bus).
// -----------------------------------------------------------------------------
interface pic_control_logic_if;

   logic       csN;
   logic       wrN;
   logic       rdN;
   logic       A0;
   logic [7:0] dataIn;

   modport master (output csN, output wrN, output rdN, output A0, output dataIn);
   modport slave  (input  csN, input  wrN, input  rdN, input  A0, input  dataIn);

endinterface

// File: rtl/pic_bus_strobe.sv
// -----------------------------------------------------------------------------
// pic_bus_strobe
// Registers the asynchronous CPU strobes and turns the rising edge of the
// registered write strobe into a single-cycle commit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   csN,wrN,rdN : raw CPU strobes (active low)
//   A0, dataIn  : raw address bit and write data
//   wr_commit   : one-cycle pulse, write completed with chip select asserted
//   a0_cmt      : A0 as seen on the last cycle the write strobe was low
//   data_cmt    : dataIn as seen on the last cycle the write strobe was low
//   rd_act      : registered read in progress (cs and rd low, no write)
//   rd_a0       : registered A0 that qualifies rd_act
// -----------------------------------------------------------------------------
module pic_bus_strobe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       csN,
   input  logic       wrN,
   input  logic       rdN,
   input  logic       A0,
   input  logic [7:0] dataIn,
   output logic       wr_commit,
   output logic       a0_cmt,
   output logic [7:0] data_cmt,
   output logic       rd_act,
   output logic       rd_a0
);

   logic       cs_p0, wr_p0, rd_p0;
   logic       cs_p1, wr_p1;
   logic       a0_p0, a0_p1;
   logic [7:0] data_p0, data_p1;

   // ---- stage p0: raw bus sampled; p1: previous-cycle copy ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_p0 <= 1'b1;
         wr_p0 <= 1'b1;
         rd_p0 <= 1'b1;
         cs_p1 <= 1'b1;
         wr_p1 <= 1'b1;
      end else begin
         cs_p0 <= csN;
         wr_p0 <= wrN;
         rd_p0 <= rdN;
         cs_p1 <= cs_p0;
         wr_p1 <= wr_p0;
      end
   end

   always_ff @(posedge clk) begin
      a0_p0   <= A0;
      data_p0 <= dataIn;
      a0_p1   <= a0_p0;
      data_p1 <= data_p0;
   end

   // ---- commit: registered wrN rose this cycle; p1 holds the last low cycle ----
   // Chip select is taken from the same cycle as the captured data so that a
   // CPU releasing csN together with wrN still produces a commit.
   assign wr_commit = ~wr_p1 & wr_p0 & ~cs_p1;
   assign a0_cmt    = a0_p1;
   assign data_cmt  = data_p1;

   // A write strobe low at the same time suppresses the read.
   assign rd_act    = ~cs_p0 & ~rd_p0 & wr_p0;
   assign rd_a0     = a0_p0;

endmodule

// File: rtl/pic_control_logic.sv
// -----------------------------------------------------------------------------
// pic_control_logic
// Command front end of an 8259A-style PIC. Decodes committed CPU writes into
// the ICW1..ICW4 initialization sequence and the OCW1..OCW3 operation
// commands, holds the resulting mode/mask registers and emits one-cycle EOI
// and rotate pulses for the in-service logic.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : CPU bus (pic_control_logic_if.slave)
//   LTIM, SNGL    : ICW1 level-trigger / single-mode bits
//   TReg          : ICW2 vector base (D7:3)
//   cascadeReg    : ICW3 contents
//   AEOI, SFNM    : ICW4 auto-EOI / special fully nested bits
//   AR            : rotate-in-AEOI enable (OCW2 set/clear)
//   IMR           : interrupt mask (OCW1)
//   readIRR/ISR/IMR : status read selects, combinational from registered strobes
//   eoiPulse, eoiSpecific, eoiLevel, rotatePulse : one-cycle OCW2 commands
//   initDone      : ICW sequence complete
//   specialMask   : special mask mode
//
// Optional feature macro: PIC_SPECIAL_MASK_EN
//   defined   : OCW3 D6:5 = 11 sets specialMask, 10 clears it
//   undefined : specialMask tied to 0, OCW3 D6:5 ignored
// -----------------------------------------------------------------------------
module pic_control_logic
   import pic_pkg::*;
#(
   parameter logic [7:0] IMR_RESET    = 8'h00,
   parameter logic       RD_SEL_RESET = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pic_control_logic_if.slave   bus,
   output logic                 LTIM,
   output logic                 SFNM,
   output logic                 AEOI,
   output logic                 AR,
   output logic [4:0]           TReg,
   output logic [7:0]           IMR,
   output logic [7:0]           cascadeReg,
   output logic                 SNGL,
   output logic                 readIRR,
   output logic                 readISR,
   output logic                 readIMR,
   output logic                 eoiPulse,
   output logic                 eoiSpecific,
   output logic [2:0]           eoiLevel,
   output logic                 rotatePulse,
   output logic                 initDone,
   output logic                 specialMask
);

   logic       wr_commit, a0_cmt, rd_act, rd_a0;
   logic [7:0] data_cmt;

   pic_state_t state, state_nxt;
   logic       ic4, ic4_nxt;
   logic       rd_sel, rd_sel_nxt;
   logic       ltim_nxt, sfnm_nxt, aeoi_nxt, ar_nxt, sngl_nxt, init_nxt;
   logic [4:0] treg_nxt;
   logic [7:0] imr_nxt, casc_nxt;
   logic       eoi_nxt, eoi_spec_nxt, rot_nxt;
   logic [2:0] eoi_lvl_nxt;

`ifdef PIC_SPECIAL_MASK_EN
   localparam logic [1:0] SMM_SET = 2'b11;
   localparam logic [1:0] SMM_CLR = 2'b10;
   logic smm, smm_nxt;
`endif

   pic_bus_strobe u_strobe (
      .clk       (clk),
      .rst_n     (rst_n),
      .csN       (bus.csN),
      .wrN       (bus.wrN),
      .rdN       (bus.rdN),
      .A0        (bus.A0),
      .dataIn    (bus.dataIn),
      .wr_commit (wr_commit),
      .a0_cmt    (a0_cmt),
      .data_cmt  (data_cmt),
      .rd_act    (rd_act),
      .rd_a0     (rd_a0)
   );

   // ---- command decode: next state and next register values ----
   always_comb begin
      state_nxt    = state;
      ic4_nxt      = ic4;
      rd_sel_nxt   = rd_sel;
      ltim_nxt     = LTIM;
      sfnm_nxt     = SFNM;
      aeoi_nxt     = AEOI;
      ar_nxt       = AR;
      sngl_nxt     = SNGL;
      init_nxt     = initDone;
      treg_nxt     = TReg;
      imr_nxt      = IMR;
      casc_nxt     = cascadeReg;
      eoi_nxt      = 1'b0;
      eoi_spec_nxt = 1'b0;
      rot_nxt      = 1'b0;
      eoi_lvl_nxt  = eoiLevel;
`ifdef PIC_SPECIAL_MASK_EN
      smm_nxt      = smm;
`endif

      if (wr_commit) begin
         if (!a0_cmt && data_cmt[ICW1_SEL]) begin
            // ICW1 restarts the sequence from any state
            ic4_nxt    = data_cmt[ICW1_IC4];
            sngl_nxt   = data_cmt[ICW1_SNGL];
            ltim_nxt   = data_cmt[ICW1_LTIM];
            sfnm_nxt   = 1'b0;
            aeoi_nxt   = 1'b0;
            ar_nxt     = 1'b0;
            init_nxt   = 1'b0;
            imr_nxt    = IMR_RESET;
            rd_sel_nxt = RD_SEL_RESET;
`ifdef PIC_SPECIAL_MASK_EN
            smm_nxt    = 1'b0;
`endif
            state_nxt  = WAIT_ICW2;
         end else if (a0_cmt) begin
            case (state)
               WAIT_ICW2: begin
                  treg_nxt = icw2_base(data_cmt);
                  if (!SNGL) begin
                     state_nxt = WAIT_ICW3;
                  end else if (ic4) begin
                     state_nxt = WAIT_ICW4;
                  end else begin
                     state_nxt = READY;
                     init_nxt  = 1'b1;
                  end
               end
               WAIT_ICW3: begin
                  casc_nxt = data_cmt;
                  if (ic4) begin
                     state_nxt = WAIT_ICW4;
                  end else begin
                     state_nxt = READY;
                     init_nxt  = 1'b1;
                  end
               end
               WAIT_ICW4: begin
                  aeoi_nxt  = data_cmt[ICW4_AEOI];
                  sfnm_nxt  = data_cmt[ICW4_SFNM];
                  state_nxt = READY;
                  init_nxt  = 1'b1;
               end
               READY: begin
                  imr_nxt = data_cmt;   // OCW1
               end
               default: begin
               end
            endcase
         end else if (state == READY) begin
            if (!data_cmt[OCW_SEL]) begin
               // OCW2
               case (data_cmt[7:5])
                  NS_EOI: begin
                     eoi_nxt     = 1'b1;
                     eoi_lvl_nxt = data_cmt[2:0];
                  end
                  S_EOI: begin
                     eoi_nxt      = 1'b1;
                     eoi_spec_nxt = 1'b1;
                     eoi_lvl_nxt  = data_cmt[2:0];
                  end
                  ROT_NS_EOI: begin
                     eoi_nxt     = 1'b1;
                     rot_nxt     = 1'b1;
                     eoi_lvl_nxt = data_cmt[2:0];
                  end
                  ROT_S_EOI: begin
                     eoi_nxt      = 1'b1;
                     eoi_spec_nxt = 1'b1;
                     rot_nxt      = 1'b1;
                     eoi_lvl_nxt  = data_cmt[2:0];
                  end
                  SET_AR:  ar_nxt = 1'b1;
                  CLR_AR:  ar_nxt = 1'b0;
                  default: begin
                  end
               endcase
            end else begin
               // OCW3: read select only moves when RR is set
               if (data_cmt[OCW3_RR]) begin
                  rd_sel_nxt = data_cmt[OCW3_RIS];
               end
`ifdef PIC_SPECIAL_MASK_EN
               if (data_cmt[6:5] == SMM_SET) begin
                  smm_nxt = 1'b1;
               end else if (data_cmt[6:5] == SMM_CLR) begin
                  smm_nxt = 1'b0;
               end
`endif
            end
         end
      end
   end

   // ---- register stage: all outputs update one clock after the commit ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ic4         <= 1'b0;
         rd_sel      <= RD_SEL_RESET;
         LTIM        <= 1'b0;
         SFNM        <= 1'b0;
         AEOI        <= 1'b0;
         AR          <= 1'b0;
         SNGL        <= 1'b0;
         initDone    <= 1'b0;
         TReg        <= 5'd0;
         IMR         <= IMR_RESET;
         cascadeReg  <= 8'd0;
         eoiPulse    <= 1'b0;
         eoiSpecific <= 1'b0;
         rotatePulse <= 1'b0;
         eoiLevel    <= 3'd0;
      end else begin
         state       <= state_nxt;
         ic4         <= ic4_nxt;
         rd_sel      <= rd_sel_nxt;
         LTIM        <= ltim_nxt;
         SFNM        <= sfnm_nxt;
         AEOI        <= aeoi_nxt;
         AR          <= ar_nxt;
         SNGL        <= sngl_nxt;
         initDone    <= init_nxt;
         TReg        <= treg_nxt;
         IMR         <= imr_nxt;
         cascadeReg  <= casc_nxt;
         eoiPulse    <= eoi_nxt;
         eoiSpecific <= eoi_spec_nxt;
         rotatePulse <= rot_nxt;
         eoiLevel    <= eoi_lvl_nxt;
      end
   end

`ifdef PIC_SPECIAL_MASK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smm <= 1'b0;
      end else begin
         smm <= smm_nxt;
      end
   end
   assign specialMask = smm;
`else
   assign specialMask = 1'b0;
`endif

   // ---- status read selects: combinational from the registered strobes ----
   assign readIMR = rd_act &  rd_a0;
   assign readIRR = rd_act & ~rd_a0 & ~rd_sel;
   assign readISR = rd_act & ~rd_a0 &  rd_sel;

endmodule
